// File: rtl/bus_map_pkg.sv
// Address map and register layout shared by the data-bus responder and its users.
package bus_map_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1000_0000;

  localparam logic [7:0] MMIO_TX          = 8'h00;
  localparam logic [7:0] MMIO_STATUS      = 8'h04;
  localparam logic [7:0] MMIO_MTIME_LO    = 8'h08;
  localparam logic [7:0] MMIO_MTIME_HI    = 8'h0C;
  localparam logic [7:0] MMIO_MTIMECMP_LO = 8'h10;
  localparam logic [7:0] MMIO_MTIMECMP_HI = 8'h14;
  localparam logic [7:0] MMIO_LEVEL       = 8'h18;

  localparam int unsigned STATUS_EMPTY_BIT = 0;
  localparam int unsigned STATUS_FULL_BIT  = 1;
  localparam int unsigned STATUS_OVF_BIT   = 2;

endpackage

// File: rtl/console_fifo.sv
// Byte-wide synchronous FIFO feeding the console transmit port.
module console_fifo #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [7:0]      din,
  input  logic            pop,
  output logic [7:0]      dout,
  output logic            empty,
  output logic            full,
  output logic [CntW-1:0] level
);

  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign level   = count_q;
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? 8'h00 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sc_data_bus_responder.sv
// Data-bus slave for the single-cycle core: byte-enabled RAM plus an MMIO block
// holding a 64-bit machine timer and a console transmit FIFO.
module sc_data_bus_responder
  import bus_map_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RAM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bus_mem_read,
  input  logic             bus_mem_write,
  input  logic [WIDTH-1:0] bus_addr_in,
  input  logic [WIDTH-1:0] bus_data_in,
  input  logic [3:0]       bus_byteen,
  output logic [WIDTH-1:0] bus_data_out,
  output logic             bus_error,
  output logic [7:0]       console_data,
  output logic             console_valid,
  input  logic             console_ready,
  output logic             timer_irq
);

  localparam int unsigned      RamAw    = $clog2(RAM_WORDS);
  localparam int unsigned      CntW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [WIDTH-1:0] RamBytes = WIDTH'(RAM_WORDS * 4);

  logic [WIDTH-1:0] ram_q [RAM_WORDS];
  logic [RamAw-1:0] ram_idx;
  logic             sel_ram, sel_mmio, unmapped;
  logic [7:0]       mmio_off;
  logic             mmio_wr, word_wr;
  logic [63:0]      mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic             irq_q, ovf_q, ovf_d;
  logic             fifo_push, fifo_empty, fifo_full;
  logic [7:0]       fifo_dout;
  logic [CntW-1:0]  fifo_level;
  logic [WIDTH-1:0] mmio_rdata;
  logic [1:0]       unused_addr;

  assign unused_addr = bus_addr_in[1:0];

  assign sel_ram   = (bus_addr_in < RamBytes);
  assign sel_mmio  = !sel_ram && (bus_addr_in[31:8] == MMIO_BASE[31:8]);
  assign unmapped  = !sel_ram && !sel_mmio;
  assign ram_idx   = bus_addr_in[RamAw+1:2];
  assign mmio_off  = {bus_addr_in[7:2], 2'b00};
  assign mmio_wr   = bus_mem_write && sel_mmio;
  assign word_wr   = mmio_wr && (bus_byteen == 4'hF);
  assign bus_error = unmapped && (bus_mem_read || bus_mem_write);

  always_ff @(posedge clk) begin
    if (bus_mem_write && sel_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (bus_byteen[i]) begin
          ram_q[ram_idx][8*i +: 8] <= bus_data_in[8*i +: 8];
        end
      end
    end
  end

  // A written MTIME half overrides that cycle's increment.
  always_comb begin
    mtime_d    = mtime_q + 64'd1;
    mtimecmp_d = mtimecmp_q;
    if (word_wr) begin
      case (mmio_off)
        MMIO_MTIME_LO:    mtime_d[31:0]     = bus_data_in;
        MMIO_MTIME_HI:    mtime_d[63:32]    = bus_data_in;
        MMIO_MTIMECMP_LO: mtimecmp_d[31:0]  = bus_data_in;
        MMIO_MTIMECMP_HI: mtimecmp_d[63:32] = bus_data_in;
        default: ;
      endcase
    end
  end

  assign fifo_push = mmio_wr && (mmio_off == MMIO_TX) && bus_byteen[0];

  // Full implies non-empty, so console_ready alone tells whether a slot frees up.
  always_comb begin
    ovf_d = ovf_q;
    if (fifo_push && fifo_full && !console_ready) begin
      ovf_d = 1'b1;
    end
    if (mmio_wr && (mmio_off == MMIO_STATUS) && bus_data_in[STATUS_OVF_BIT]) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      irq_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      irq_q      <= (mtime_q >= mtimecmp_q);
      ovf_q      <= ovf_d;
    end
  end

  console_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_console_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (bus_data_in[7:0]),
    .pop   (console_ready),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  assign console_valid = !fifo_empty;
  assign console_data  = fifo_dout;
  assign timer_irq     = irq_q;

  always_comb begin
    mmio_rdata = '0;
    case (mmio_off)
      MMIO_STATUS: begin
        mmio_rdata[STATUS_EMPTY_BIT] = fifo_empty;
        mmio_rdata[STATUS_FULL_BIT]  = fifo_full;
        mmio_rdata[STATUS_OVF_BIT]   = ovf_q;
      end
      MMIO_MTIME_LO:    mmio_rdata = mtime_q[31:0];
      MMIO_MTIME_HI:    mmio_rdata = mtime_q[63:32];
      MMIO_MTIMECMP_LO: mmio_rdata = mtimecmp_q[31:0];
      MMIO_MTIMECMP_HI: mmio_rdata = mtimecmp_q[63:32];
      MMIO_LEVEL:       mmio_rdata = WIDTH'(fifo_level);
      default: ;
    endcase
  end

  always_comb begin
    bus_data_out = '0;
    if (bus_mem_read) begin
      if (sel_ram) begin
        bus_data_out = ram_q[ram_idx];
      end else if (sel_mmio) begin
        bus_data_out = mmio_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sc_data_bus_responder.sv
// Bench for sc_data_bus_responder: directed scenarios plus randomized traffic
// checked against a queue/array reference model of the bus map.
module tb_sc_data_bus_responder;

  localparam logic [31:0] MB    = 32'h1000_0000;
  localparam int          Depth = 4;

  logic        clk, reset, rd, wr, ready;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic        err, cvalid, irq;
  logic [7:0]  cdata;

  int passed, total;

  logic [31:0] m_ram [int unsigned];
  logic [7:0]  m_fifo [$];
  logic        m_ovf, m_irq;
  logic [63:0] m_mtime, m_cmp;

  sc_data_bus_responder #(
    .WIDTH(32),
    .RAM_WORDS(1024),
    .MMIO_BASE(MB),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus_mem_read  (rd),
    .bus_mem_write (wr),
    .bus_addr_in   (addr),
    .bus_data_in   (wdata),
    .bus_byteen    (be),
    .bus_data_out  (rdata),
    .bus_error     (err),
    .console_data  (cdata),
    .console_valid (cvalid),
    .console_ready (ready),
    .timer_irq     (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic model_reset();
    m_fifo.delete();
    m_ovf   = 1'b0;
    m_irq   = 1'b0;
    m_mtime = 64'd0;
    m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [7:0]  off;
    int unsigned idx;
    off = {a[7:2], 2'b00};
    idx = a >> 2;
    if (a < 32'h1000) return m_ram.exists(idx) ? m_ram[idx] : 32'hx;
    if (a[31:8] != 24'h10_0000) return 32'd0;
    case (off)
      8'h04: return {29'd0, m_ovf, m_fifo.size() == Depth, m_fifo.size() == 0};
      8'h08: return m_mtime[31:0];
      8'h0C: return m_mtime[63:32];
      8'h10: return m_cmp[31:0];
      8'h14: return m_cmp[63:32];
      8'h18: return 32'(m_fifo.size());
      default: return 32'd0;
    endcase
  endfunction

  // Advance one clock: model the edge from the currently driven inputs.
  task automatic step();
    logic [63:0] n_mtime, n_cmp;
    logic        n_irq, n_ovf, mm;
    logic [7:0]  q [$];
    logic [7:0]  off;
    int unsigned idx;
    logic [31:0] w;
    n_mtime = m_mtime + 64'd1;
    n_cmp   = m_cmp;
    n_irq   = (m_mtime >= m_cmp);
    n_ovf   = m_ovf;
    q       = m_fifo;
    off     = {addr[7:2], 2'b00};
    mm      = (addr[31:8] == 24'h10_0000);
    if (ready && q.size() > 0) void'(q.pop_front());
    if (wr && addr < 32'h1000) begin
      idx = addr >> 2;
      w   = m_ram.exists(idx) ? m_ram[idx] : 32'hx;
      for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
      m_ram[idx] = w;
    end else if (wr && mm) begin
      case (off)
        8'h00: if (be[0]) begin
          if (q.size() < Depth) q.push_back(wdata[7:0]);
          else n_ovf = 1'b1;
        end
        8'h04: if (wdata[2]) n_ovf = 1'b0;
        8'h08: if (be == 4'hF) n_mtime[31:0] = wdata;
        8'h0C: if (be == 4'hF) n_mtime[63:32] = wdata;
        8'h10: if (be == 4'hF) n_cmp[31:0] = wdata;
        8'h14: if (be == 4'hF) n_cmp[63:32] = wdata;
        default: ;
      endcase
    end
    @(posedge clk);
    m_mtime = n_mtime;
    m_cmp   = n_cmp;
    m_irq   = n_irq;
    m_ovf   = n_ovf;
    m_fifo  = q;
    @(negedge clk);
  endtask

  task automatic set_idle();
    rd = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'd0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    wr = 1'b1; addr = a; wdata = d; be = b;
    step();
    wr = 1'b0; be = 4'd0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic e);
    rd = 1'b1; addr = a;
    #1;
    d = rdata; e = err;
    rd = 1'b0;
  endtask

  task automatic drain();
    ready = 1'b1;
    repeat (Depth + 2) step();
    ready = 1'b0;
    do_write(MB + 32'h04, 32'h4, 4'hF);
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e;
    addr = 32'h40; #1;
    total++; if (rdata !== 32'd0) $display("FAIL reset_rdata got=%h exp=0", rdata); else passed++;
    total++; if (cvalid !== 1'b0) $display("FAIL reset_cvalid got=%b exp=0", cvalid); else passed++;
    total++; if (cdata !== 8'd0) $display("FAIL reset_cdata got=%h exp=0", cdata); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", irq); else passed++;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    model_reset();
    do_read(MB + 32'h10, d, e);
    total++; if (d !== 32'hFFFF_FFFF) $display("FAIL reset_cmp_lo got=%h exp=ffffffff", d); else passed++;
    do_read(MB + 32'h08, d, e);
    total++; if (d !== 32'd0) $display("FAIL reset_mtime_lo got=%h exp=0", d); else passed++;
    do_read(MB + 32'h04, d, e);
    total++; if (d !== 32'd1) $display("FAIL reset_status got=%h exp=1", d); else passed++;
  endtask

  task automatic test_ram_lanes();
    logic [31:0] d; logic e;
    do_write(32'h40, 32'hAABB_CCDD, 4'hF);
    do_write(32'h40, 32'h0000_1100, 4'b0010);
    do_read(32'h40, d, e);
    total++; if (d !== 32'hAABB_11DD) $display("FAIL ram_lanes got=%h exp=aabb11dd", d); else passed++;
    total++; if (e !== 1'b0) $display("FAIL ram_err got=%b exp=0", e); else passed++;
    do_write(32'hFFC, 32'h1234_5678, 4'b1001);
    do_write(32'hFFC, 32'h0000_0000, 4'b0110);
    do_read(32'hFFC, d, e);
    total++; if (d !== 32'h1200_0078) $display("FAIL ram_top_word got=%h exp=12000078", d); else passed++;
  endtask

  task automatic test_unmapped();
    logic [31:0] d, st; logic e;
    do_read(32'h2000_0000, d, e);
    total++; if (e !== 1'b1) $display("FAIL unmapped_err got=%b exp=1", e); else passed++;
    total++; if (d !== 32'd0) $display("FAIL unmapped_data got=%h exp=0", d); else passed++;
    wr = 1'b1; addr = 32'h2000_0000; wdata = 32'hDEAD_BEEF; be = 4'hF;
    #1;
    total++; if (err !== 1'b1) $display("FAIL unmapped_wr_err got=%b exp=1", err); else passed++;
    step();
    wr = 1'b0;
    do_read(32'h40, d, e);
    total++; if (d !== 32'hAABB_11DD) $display("FAIL unmapped_ram_kept got=%h exp=aabb11dd", d); else passed++;
    do_read(MB + 32'h04, st, e);
    total++; if (st !== m_read(MB + 32'h04)) $display("FAIL unmapped_status got=%h exp=%h", st, m_read(MB + 32'h04)); else passed++;
    do_read(MB + 32'h1C, d, e);
    total++; if (e !== 1'b0 || d !== 32'd0) $display("FAIL mmio_hole got=%b/%h exp=0/0", e, d); else passed++;
  endtask

  task automatic test_console();
    logic [31:0] d; logic e;
    drain();
    for (int i = 0; i < 5; i++) do_write(MB, 32'h41 + 32'(i), 4'b0001);
    do_read(MB + 32'h18, d, e);
    total++; if (d !== 32'd4) $display("FAIL con_level got=%h exp=4", d); else passed++;
    do_read(MB + 32'h04, d, e);
    total++; if (d !== 32'd6) $display("FAIL con_status got=%h exp=6", d); else passed++;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (cvalid !== 1'b1 || cdata !== 8'h41 + 8'(i))
        $display("FAIL con_emit%0d got=%b/%h exp=1/%h", i, cvalid, cdata, 8'h41 + 8'(i));
      else passed++;
      step();
    end
    total++; if (cvalid !== 1'b0) $display("FAIL con_drained got=%b exp=0", cvalid); else passed++;
    ready = 1'b0;
    do_write(MB + 32'h04, 32'd4, 4'hF);
    do_read(MB + 32'h04, d, e);
    total++; if (d !== 32'd1) $display("FAIL con_ovf_clear got=%h exp=1", d); else passed++;
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d; logic e;
    logic [7:0]  seen [$];
    drain();
    for (int i = 0; i < 4; i++) do_write(MB, 32'h61 + 32'(i), 4'b0001);
    ready = 1'b1;
    do_write(MB, 32'h58, 4'b0001);
    ready = 1'b0;
    do_read(MB + 32'h18, d, e);
    total++; if (d !== 32'd4) $display("FAIL fpp_level got=%h exp=4", d); else passed++;
    do_read(MB + 32'h04, d, e);
    total++; if (d !== 32'd2) $display("FAIL fpp_status got=%h exp=2", d); else passed++;
    ready = 1'b1;
    for (int i = 0; i < 6 && cvalid === 1'b1; i++) begin
      seen.push_back(cdata);
      step();
    end
    ready = 1'b0;
    total++;
    if (seen.size() != 4 || seen[3] !== 8'h58)
      $display("FAIL fpp_order got=%0d bytes last=%h exp=4 bytes last=58",
               seen.size(), seen.size() > 0 ? seen[seen.size()-1] : 8'h00);
    else passed++;
  endtask

  task automatic test_timer();
    logic [31:0] d; logic e;
    int          c;
    do_write(MB + 32'h0C, 32'd0, 4'hF);
    do_write(MB + 32'h08, 32'd0, 4'hF);
    do_write(MB + 32'h14, 32'd0, 4'hF);
    do_write(MB + 32'h10, 32'd20, 4'hF);
    do_write(MB + 32'h08, 32'd10, 4'hF);
    c = 0;
    while (irq !== 1'b1 && c < 30) begin
      total++; if (irq !== m_irq) $display("FAIL tmr_irq_model got=%b exp=%b", irq, m_irq); else passed++;
      step();
      c++;
    end
    total++; if (c != 11) $display("FAIL tmr_rise got=%0d cycles exp=11", c); else passed++;
    do_write(MB + 32'h10, 32'd5, 4'h3);
    do_read(MB + 32'h10, d, e);
    total++; if (d !== 32'd20) $display("FAIL tmr_partial got=%h exp=14", d); else passed++;
    do_write(MB + 32'h14, 32'd1, 4'hF);
    total++; if (irq !== 1'b1) $display("FAIL tmr_hold got=%b exp=1", irq); else passed++;
    step();
    total++; if (irq !== 1'b0) $display("FAIL tmr_fall got=%b exp=0", irq); else passed++;
    do_write(MB + 32'h0C, 32'hFFFF_FFFF, 4'hF);
    do_write(MB + 32'h08, 32'hFFFF_FFFD, 4'hF);
    for (int i = 0; i < 5; i++) begin
      do_read(MB + 32'h08, d, e);
      total++; if (d !== m_mtime[31:0]) $display("FAIL tmr_wrap_lo%0d got=%h exp=%h", i, d, m_mtime[31:0]); else passed++;
      do_read(MB + 32'h0C, d, e);
      total++; if (d !== m_mtime[63:32]) $display("FAIL tmr_wrap_hi%0d got=%h exp=%h", i, d, m_mtime[63:32]); else passed++;
      total++; if (irq !== m_irq) $display("FAIL tmr_wrap_irq%0d got=%b exp=%b", i, irq, m_irq); else passed++;
      if (i == 3) begin
        total++; if (m_mtime !== 64'd0) $display("FAIL tmr_wrap_zero got=%h exp=0", m_mtime); else passed++;
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [31:0] d, a, x; logic e;
    for (int i = 0; i < 16; i++) do_write(32'h100 + 32'(4*i), $urandom, 4'hF);
    for (int i = 0; i < 300; i++) begin
      int op;
      op    = $urandom_range(0, 5);
      ready = 1'($urandom_range(0, 1));
      x     = m_fifo.size() != 0 ? 32'(m_fifo[0]) : 32'd0;
      total++;
      if (cvalid !== (m_fifo.size() != 0) || cdata !== x[7:0] || irq !== m_irq)
        $display("FAIL rnd_out%0d got=%b/%h/%b exp=%b/%h/%b", i, cvalid, cdata, irq,
                 m_fifo.size() != 0, x[7:0], m_irq);
      else passed++;
      case (op)
        0: do_write(32'h100 + 32'(4*$urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
        1, 3: begin
          a = (op == 1) ? 32'h100 + 32'(4*$urandom_range(0, 15)) : MB + 32'(4*$urandom_range(0, 9));
          do_read(a, d, e);
          total++;
          if (d !== m_read(a) || e !== 1'b0) $display("FAIL rnd_rd%0d a=%h got=%h exp=%h", i, a, d, m_read(a));
          else passed++;
          step();
        end
        2: do_write(MB, $urandom, 4'($urandom_range(0, 15)));
        4: do_write(MB + 32'h04, $urandom, 4'hF);
        default: begin
          a = {4'($urandom_range(2, 15)), 28'($urandom)};
          rd = 1'($urandom_range(0, 1)); wr = !rd; addr = a; wdata = $urandom; be = 4'hF;
          #1;
          total++;
          if (err !== 1'b1 || rdata !== 32'd0) $display("FAIL rnd_unmapped%0d got=%b/%h exp=1/0", i, err, rdata);
          else passed++;
          step();
          set_idle();
        end
      endcase
    end
    ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic e;
    drain();
    for (int i = 0; i < 3; i++) do_write(MB, 32'h70 + 32'(i), 4'b0001);
    do_write(MB + 32'h0C, 32'd0, 4'hF);
    do_write(MB + 32'h08, 32'd500, 4'hF);
    do_write(MB + 32'h14, 32'd0, 4'hF);
    do_write(MB + 32'h10, 32'd20, 4'hF);
    step();
    total++; if (irq !== 1'b1 || cvalid !== 1'b1) $display("FAIL rst_pre got=%b/%b exp=1/1", irq, cvalid); else passed++;
    #3 reset = 1'b0;
    model_reset();
    #1;
    total++; if (cvalid !== 1'b0 || irq !== 1'b0 || cdata !== 8'd0)
      $display("FAIL rst_async got=%b/%b/%h exp=0/0/00", cvalid, irq, cdata);
    else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    do_read(MB + 32'h18, d, e);
    total++; if (d !== 32'd0) $display("FAIL rst_level got=%h exp=0", d); else passed++;
    repeat (3) step();
    do_read(MB + 32'h08, d, e);
    total++; if (d !== 32'd3) $display("FAIL rst_mtime got=%h exp=3", d); else passed++;
    total++; if (irq !== 1'b0 || cvalid !== 1'b0) $display("FAIL rst_post got=%b/%b exp=0/0", irq, cvalid); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    set_idle();
    ready = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    test_reset();
    test_ram_lanes();
    test_unmapped();
    test_console();
    test_full_push_pop();
    test_timer();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
